// File: rtl/fixed_pkg.sv
// Q14.18 fixed-point types and the shared-multiplier arbiter state encoding.
package fixed_pkg;

    localparam int unsigned FIXED_FRAC_BITS = 18;

    typedef logic signed [31:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } mul_arb_state_t;

endpackage

// File: rtl/fixed_mul.sv
// Combinational Q14.18 multiply, truncated (floor) back to Q14.18, wrapping on overflow.
module fixed_mul
    import fixed_pkg::*;
(
    input  fixed_t a,
    input  fixed_t b,
    output fixed_t r
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;

    always_comb begin
        a_ext = 64'(a);
        b_ext = 64'(b);
        prod  = a_ext * b_ext;
        r     = fixed_t'(prod >>> FIXED_FRAC_BITS);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N   = 4,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic [IDW-1:0] cand;

    // Scan farthest-to-nearest so the nearest valid requester overwrites the rest.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            cand = IDW'((32'(last_grant) + k) % N);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fixed_mul_arbiter.sv
// Round-robin sharing of one fixed_mul among N_REQ valid/ready requesters.
// Define FIXED_MUL_ARB_PIPE_EN to register operands ahead of the multiplier (MUL state, 2-cycle latency).
module fixed_mul_arbiter
    import fixed_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic   [N_REQ-1:0]   req_valid,
    input  fixed_t [N_REQ-1:0]   req_a,
    input  fixed_t [N_REQ-1:0]   req_b,
    output logic   [N_REQ-1:0]   req_ready,
    output logic   [N_REQ-1:0]   rsp_valid,
    input  logic   [N_REQ-1:0]   rsp_ready,
    output fixed_t               rsp_r,
    output logic   [IDW-1:0]     rsp_id
);

`ifdef FIXED_MUL_ARB_PIPE_EN
    localparam mul_arb_state_t GRANT_STATE = MUL;
`else
    localparam mul_arb_state_t GRANT_STATE = RESP;
`endif

    mul_arb_state_t   state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    fixed_t           rsp_r_q, rsp_r_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             accept;
    logic             can_accept;
    logic             grant;
    fixed_t           mul_a, mul_b, mul_r;

`ifdef FIXED_MUL_ARB_PIPE_EN
    fixed_t           op_a_q, op_a_d;
    fixed_t           op_b_q, op_b_d;
    logic [IDW-1:0]   op_id_q, op_id_d;

    assign mul_a = op_a_q;
    assign mul_b = op_b_q;
`else
    assign mul_a = req_a[arb_idx];
    assign mul_b = req_b[arb_idx];
`endif

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    fixed_mul u_fixed_mul (
        .a (mul_a),
        .b (mul_b),
        .r (mul_r)
    );

    // Draining the held response frees the multiplier for a grant in the same cycle.
    assign accept     = (state_q == RESP) && rsp_ready[rsp_id_q];
    assign can_accept = (state_q == IDLE) || accept;
    assign grant      = rst_n && can_accept && (|req_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) state_d = GRANT_STATE;
            end
            MUL: begin
                state_d = RESP;
            end
            RESP: begin
                if (grant) begin
                    state_d = GRANT_STATE;
                end else if (accept) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready    = grant ? arb_gnt : '0;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_r_d      = rsp_r_q;
        rsp_id_d     = rsp_id_q;
        if (accept) begin
            rsp_valid_d = '0;
        end
        if (grant) begin
            last_grant_d = arb_idx;
        end
`ifdef FIXED_MUL_ARB_PIPE_EN
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_id_d = op_id_q;
        if (grant) begin
            op_a_d  = req_a[arb_idx];
            op_b_d  = req_b[arb_idx];
            op_id_d = arb_idx;
        end
        if (state_q == MUL) begin
            rsp_r_d              = mul_r;
            rsp_id_d             = op_id_q;
            rsp_valid_d          = '0;
            rsp_valid_d[op_id_q] = 1'b1;
        end
`else
        if (grant) begin
            rsp_r_d              = mul_r;
            rsp_id_d             = arb_idx;
            rsp_valid_d          = '0;
            rsp_valid_d[arb_idx] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= IDW'(N_REQ - 1);
            rsp_valid_q  <= '0;
            rsp_r_q      <= '0;
            rsp_id_q     <= '0;
`ifdef FIXED_MUL_ARB_PIPE_EN
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
`endif
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_r_q      <= rsp_r_d;
            rsp_id_q     <= rsp_id_d;
`ifdef FIXED_MUL_ARB_PIPE_EN
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: doc/fixed_mul_arbiter.md
# fixed_mul_arbiter

Round-robin arbiter that shares one combinational `fixed_mul` among `N_REQ` requesters (e.g. map-gradient, pose-update and Hessian-accumulate units of the scan matcher). Each requester presents an operand pair under a valid/ready handshake. The arbiter grants one pair at a time, registers the product, and returns it to the granted requester with a one-hot response valid and a back-pressurable response handshake.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `req_valid  in  N_REQ`: requester i has an operand pair.
- `req_a  in  N_REQ x fixed_t`: operand a per requester, Q14.18 signed.
- `req_b  in  N_REQ x fixed_t`: operand b per requester.
- `req_ready  out  N_REQ`: one-hot grant; the pair transfers on `req_valid[i] & req_ready[i]`.
- `rsp_valid  out  N_REQ`: one-hot; the result is for requester i.
- `rsp_ready  in  N_REQ`: requester i accepts its result.
- `rsp_r  out  fixed_t`: product, meaningful only while any `rsp_valid` bit is set.
- `rsp_id  out  $clog2(N_REQ)`: index of the requester that owns `rsp_r`.

## Operation
- States are IDLE, MUL and RESP. MUL exists only with `FIXED_MUL_ARB_PIPE_EN`.
- Can-accept condition: state is IDLE, or state is RESP and `rsp_valid[rsp_id] & rsp_ready[rsp_id]` in this cycle (same-cycle drain and refill).
- When it can accept, the arbiter picks the first i with `req_valid[i]`, searching from `last_grant+1` modulo `N_REQ`. It asserts `req_ready[i]` combinationally and no other bit.
- `req_ready` is all zero when the arbiter cannot accept or no request is valid. It never depends on other requesters' `rsp_ready`.
- On grant, `last_grant` takes i.
- On grant without the macro: `rsp_r` captures `fixed_mul(req_a[i], req_b[i])`, `rsp_id` captures i, `rsp_valid` becomes one-hot i, and the state goes to RESP.
- On grant with the macro: the operands and i are registered and the state goes to MUL. The following cycle moves the product to the response registers and goes to RESP.
- In RESP, `rsp_r`, `rsp_id` and `rsp_valid` stay stable until accepted.
- On accept with no new grant: `rsp_valid` goes to 0 and the state goes to IDLE.
- Requesters hold `req_valid` and operands stable until granted. Dropping valid before the grant is allowed; that request is simply not served.
- Arithmetic is exactly `fixed_mul`: Q14.18 × Q14.18, result truncated to Q14.18 with no saturation. The arbiter adds no rounding.
- Fairness: a continuously valid requester is granted within `N_REQ` grants.

## Timing
- Reset values: `req_ready`=0 combinationally while `rst_n`=0, `rsp_valid`=0, `rsp_r`=0, `rsp_id`=0, state IDLE, `last_grant`=`N_REQ-1` (requester 0 has first priority).
- Latency from grant cycle t to `rsp_valid`: t+1 without the macro, t+2 with it.
- Throughput with `rsp_ready` held high: 1 product/cycle without the macro, 1 per 2 cycles with it (no grant while in MUL).
- Reset asserted mid-operation, in MUL or RESP: the in-flight product is discarded, nothing is returned, and all registers take their reset values on that edge.
- `rsp_ready` asserted for a non-owning requester has no effect.
- Simultaneous requests from all requesters: grants follow strict rotation, e.g. 0,1,2,3,0,...

## Configuration
- `FIXED_MUL_ARB_PIPE_EN` defined: an operand register stage is inserted before `fixed_mul`, adding the MUL state. This breaks the mux → multiplier → register timing path at the cost of 2-cycle latency.
- `FIXED_MUL_ARB_PIPE_EN` undefined: single register stage, 1-cycle latency, no MUL state.

## Structure
- `fixed_pkg` holds `fixed_t` (32-bit signed), `FIXED_FRAC_BITS`=18 and `mul_arb_state_t` (IDLE, MUL, RESP).
- Sub-module `rr_arbiter`, combinational:
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant and grant index.
  - Reusable for other shared datapaths.
- One `fixed_mul` instance, fed by the operand mux (or by the operand registers when the macro is defined).

## Test plan
- Single request, requester 0: a=0x00020000 (0.5), b=0x00080000 (2) → `rsp_valid`=0001, `rsp_r`=0x00040000, `rsp_id`=0. Arrives at t+1, or t+2 with the macro.
- Signed: requester 2, a=0x000C0000 (3), b=0xFFFA0000 (-1.5) → `rsp_r`=0xFFEE0000 (-4.5), `rsp_valid`=0100.
- All 4 requesters valid, `rsp_ready` high → grant order 0,1,2,3,0. Without the macro there is one `rsp_valid` per cycle with no gaps.
- Back-pressure: hold `rsp_ready[1]`=0 for 5 cycles → `rsp_r`/`rsp_id` stable, `req_ready`=0 throughout. Releasing it grants the next requester in the same cycle.
- Reset in RESP state → next cycle `rsp_valid`=0, state IDLE. After reset, requesters 0 and 3 valid together → requester 0 granted first.
- `rsp_ready` driven by the wrong requester (3, while the result is for 1) → result is not consumed and `rsp_valid` stays 0010.
